// File: rtl/count_run_controller.sv
// Run/pause/abort sequencer for the auto-increment counter: owns the tick timebase and issues inc/clr pulses.
// Registered outputs appear one cycle after the deciding edge; button actions land SYNC_STAGES+1 cycles after the press.
module count_run_controller #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int TICK_HZ     = 1,
    parameter int LIMIT       = 150,
    parameter int STEP_SMALL  = 1,
    parameter int STEP_LARGE  = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start_btn,
    input  logic       i_pause_btn,
    input  logic       i_step_sel,
    input  logic [7:0] i_count_value,
    output logic       o_inc_pulse,
    output logic [7:0] o_inc_amount,
    output logic       o_clr_pulse,
    output logic       o_running,
    output logic       o_done,
    output logic       o_anim_start,
    output logic [1:0] o_state_code
);

    localparam int              TDIV     = CLK_FREQ / TICK_HZ;
    localparam int              DIV_W    = (TDIV > 1) ? $clog2(TDIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TDIV - 1);
    localparam logic [7:0]      LIMIT_V  = 8'(LIMIT);
    localparam logic [7:0]      STEP_S   = 8'(STEP_SMALL);
    localparam logic [7:0]      STEP_L   = 8'(STEP_LARGE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_start_sync;
    logic [SYNC_STAGES-1:0] r_pause_sync;
    logic                   r_start_prev;
    logic                   r_pause_prev;

    state_t                 r_state;
    logic [DIV_W-1:0]       r_div;
    logic                   r_inc;
    logic [7:0]             r_amt;
    logic                   r_clr;
    logic                   r_running;
    logic                   r_done;
    logic                   r_anim;

    logic                   w_start_e;
    logic                   w_pause_e;
    logic                   w_tick;
    logic [7:0]             w_step;
    logic [8:0]             w_sum;
    logic                   w_at_limit;
    logic [7:0]             w_amount;

    state_t                 w_state_nxt;
    logic [DIV_W-1:0]       w_div_nxt;
    logic                   w_inc_nxt;
    logic [7:0]             w_amt_nxt;
    logic                   w_clr_nxt;
    logic                   w_anim_nxt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_start_sync <= '0;
            r_pause_sync <= '0;
            r_start_prev <= 1'b0;
            r_pause_prev <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], i_start_btn};
            r_pause_sync <= {r_pause_sync[SYNC_STAGES-2:0], i_pause_btn};
            r_start_prev <= r_start_sync[SYNC_STAGES-1];
            r_pause_prev <= r_pause_sync[SYNC_STAGES-1];
        end
    end

    assign w_start_e = r_start_sync[SYNC_STAGES-1] & ~r_start_prev;
    assign w_pause_e = r_pause_sync[SYNC_STAGES-1] & ~r_pause_prev;

    // The final step is trimmed so the counter lands exactly on LIMIT.
    assign w_tick     = (r_div == DIV_LAST);
    assign w_step     = i_step_sel ? STEP_L : STEP_S;
    assign w_sum      = {1'b0, i_count_value} + {1'b0, w_step};
    assign w_at_limit = (i_count_value >= LIMIT_V);
    assign w_amount   = (w_sum > {1'b0, LIMIT_V}) ? (LIMIT_V - i_count_value) : w_step;

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_inc_nxt   = 1'b0;
        w_amt_nxt   = 8'd0;
        w_clr_nxt   = 1'b0;
        w_anim_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_pause_e && w_start_e) begin
                    w_state_nxt = S_RUN;
                    w_clr_nxt   = 1'b1;
                    w_div_nxt   = '0;
                end
            end
            S_RUN: begin
                // Pause outranks a coinciding tick; the divider freezes where it is.
                if (w_pause_e) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_tick) begin
                    w_div_nxt = '0;
                    if (w_at_limit) begin
                        w_state_nxt = S_DONE;
                        w_anim_nxt  = 1'b1;
                    end else begin
                        w_inc_nxt = 1'b1;
                        w_amt_nxt = w_amount;
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_PAUSE: begin
                if (w_pause_e) begin
                    w_state_nxt = S_IDLE;
                    w_clr_nxt   = 1'b1;
                end else if (w_start_e) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (w_pause_e) begin
                    w_state_nxt = S_IDLE;
                    w_clr_nxt   = 1'b1;
                end else if (w_start_e) begin
                    w_state_nxt = S_RUN;
                    w_clr_nxt   = 1'b1;
                    w_div_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_inc     <= 1'b0;
            r_amt     <= 8'd0;
            r_clr     <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_anim    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_inc     <= w_inc_nxt;
            r_amt     <= w_amt_nxt;
            r_clr     <= w_clr_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
            r_anim    <= w_anim_nxt;
        end
    end

    assign o_inc_pulse  = r_inc;
    assign o_inc_amount = r_amt;
    assign o_clr_pulse  = r_clr;
    assign o_running    = r_running;
    assign o_done       = r_done;
    assign o_anim_start = r_anim;
    assign o_state_code = r_state;

    a_no_clr_with_inc : assert property (@(posedge i_clk) disable iff (i_reset)
        !(o_inc_pulse && o_clr_pulse));
    a_amount_idle_zero : assert property (@(posedge i_clk) disable iff (i_reset)
        o_inc_pulse || (o_inc_amount == 8'd0));

endmodule

// File: tb/tb_count_run_controller.sv
// Directed bench for count_run_controller with TDIV=10 and two-stage button synchronizers.
// The bench plays the counter datapath itself so count_value follows the issued pulses.
module tb_count_run_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       step_sel = 1'b0;
    logic [7:0] count_value = 8'd0;
    logic       o_inc_pulse;
    logic [7:0] o_inc_amount;
    logic       o_clr_pulse;
    logic       o_running;
    logic       o_done;
    logic       o_anim_start;
    logic [1:0] o_state_code;

    int n_vec = 0;
    int n_bad = 0;
    bit model_en = 1'b1;

    typedef struct {
        int          start;
        int          pause;
        int          step;
        int          adv;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[19];

    always #5 clk = ~clk;

    count_run_controller #(
        .CLK_FREQ   (10),
        .TICK_HZ    (1),
        .LIMIT      (150),
        .STEP_SMALL (1),
        .STEP_LARGE (10),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start_btn  (start_btn),
        .i_pause_btn  (pause_btn),
        .i_step_sel   (step_sel),
        .i_count_value(count_value),
        .o_inc_pulse  (o_inc_pulse),
        .o_inc_amount (o_inc_amount),
        .o_clr_pulse  (o_clr_pulse),
        .o_running    (o_running),
        .o_done       (o_done),
        .o_anim_start (o_anim_start),
        .o_state_code (o_state_code)
    );

    function automatic logic [14:0] exp_o(input int inc, input int amt, input int clr, input int run,
                                          input int done, input int anim, input int st);
        return {inc[0], amt[7:0], clr[0], run[0], done[0], anim[0], st[1:0]};
    endfunction

    function automatic logic [14:0] obs();
        return {o_inc_pulse, o_inc_amount, o_clr_pulse, o_running, o_done, o_anim_start, o_state_code};
    endfunction

    function automatic string fmt(input logic [14:0] v);
        return $sformatf("inc=%0b amt=%0d clr=%0b run=%0b done=%0b anim=%0b st=%0d",
                         v[14], v[13:6], v[5], v[4], v[3], v[2], v[1:0]);
    endfunction

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] got;
        got = obs();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {%s} want {%s}", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // One clock; the datapath model reacts to the pulses just registered.
    task automatic step();
        @(posedge clk);
        #1;
        if (model_en) begin
            if (o_clr_pulse) count_value = 8'd0;
            else if (o_inc_pulse) count_value = count_value + o_inc_amount;
        end
    endtask

    task automatic press(input bit s, input bit p);
        start_btn = s;
        pause_btn = p;
        repeat (3) step();
        start_btn = 1'b0;
        pause_btn = 1'b0;
    endtask

    task automatic wait_event(input int budget, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!(o_inc_pulse || o_anim_start) && cyc < budget);
    endtask

    task automatic do_reset(input string name);
        start_btn = 1'b0;
        pause_btn = 1'b0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check(name, exp_o(0, 0, 0, 0, 0, 0, 0));
        step();
        step();
        rst = 1'b0;
        count_value = 8'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int seen;

        // Start, two steps of 1, pause at divider=4 for 30 cycles, resume, then abort from PAUSE.
        tbl[0]  = '{1, 0, 0, 2,  exp_o(0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1, 0, 0, 1,  exp_o(0, 0, 1, 1, 0, 0, 1)};
        tbl[2]  = '{0, 0, 0, 1,  exp_o(0, 0, 0, 1, 0, 0, 1)};
        tbl[3]  = '{0, 0, 0, 8,  exp_o(0, 0, 0, 1, 0, 0, 1)};
        tbl[4]  = '{0, 0, 0, 1,  exp_o(1, 1, 0, 1, 0, 0, 1)};
        tbl[5]  = '{0, 0, 0, 1,  exp_o(0, 0, 0, 1, 0, 0, 1)};
        tbl[6]  = '{0, 0, 0, 9,  exp_o(1, 1, 0, 1, 0, 0, 1)};
        tbl[7]  = '{0, 0, 0, 2,  exp_o(0, 0, 0, 1, 0, 0, 1)};
        tbl[8]  = '{0, 1, 0, 2,  exp_o(0, 0, 0, 1, 0, 0, 1)};
        tbl[9]  = '{0, 1, 0, 1,  exp_o(0, 0, 0, 0, 0, 0, 2)};
        tbl[10] = '{0, 0, 0, 30, exp_o(0, 0, 0, 0, 0, 0, 2)};
        tbl[11] = '{1, 0, 0, 3,  exp_o(0, 0, 0, 1, 0, 0, 1)};
        tbl[12] = '{0, 0, 0, 5,  exp_o(0, 0, 0, 1, 0, 0, 1)};
        tbl[13] = '{0, 0, 0, 1,  exp_o(1, 1, 0, 1, 0, 0, 1)};
        tbl[14] = '{0, 0, 0, 1,  exp_o(0, 0, 0, 1, 0, 0, 1)};
        tbl[15] = '{0, 1, 0, 3,  exp_o(0, 0, 0, 0, 0, 0, 2)};
        tbl[16] = '{0, 0, 0, 2,  exp_o(0, 0, 0, 0, 0, 0, 2)};
        tbl[17] = '{0, 1, 0, 3,  exp_o(0, 0, 1, 0, 0, 0, 0)};
        tbl[18] = '{0, 0, 0, 1,  exp_o(0, 0, 0, 0, 0, 0, 0)};

        do_reset("reset_initial");
        for (int i = 0; i < 19; i++) begin
            start_btn = tbl[i].start[0];
            pause_btn = tbl[i].pause[0];
            step_sel  = tbl[i].step[0];
            repeat (tbl[i].adv) step();
            check($sformatf("tbl[%0d]", i), tbl[i].exp);
        end
        start_btn = 1'b0;
        pause_btn = 1'b0;

        // Large steps from 0 up to LIMIT, then completion on the following tick.
        do_reset("reset_t2");
        model_en = 1'b1;
        step_sel = 1'b1;
        press(1'b1, 1'b0);
        check("t2_start", exp_o(0, 0, 1, 1, 0, 0, 1));
        for (int k = 0; k < 15; k++) begin
            wait_event(12, cyc);
            check_int($sformatf("t2_gap[%0d]", k), cyc, 10);
            check($sformatf("t2_inc[%0d]", k), exp_o(1, 10, 0, 1, 0, 0, 1));
        end
        check_int("t2_count", int'(count_value), 150);
        wait_event(12, cyc);
        check_int("t2_done_gap", cyc, 10);
        check("t2_done", exp_o(0, 0, 0, 0, 1, 1, 3));
        step();
        check("t2_done_hold", exp_o(0, 0, 0, 0, 1, 0, 3));

        // Clamping near LIMIT with a frozen count_value.
        do_reset("reset_t3");
        model_en = 1'b0;
        step_sel = 1'b1;
        press(1'b1, 1'b0);
        count_value = 8'd149;
        wait_event(12, cyc);
        check("t3_clamp149", exp_o(1, 1, 0, 1, 0, 0, 1));
        count_value = 8'd145;
        wait_event(12, cyc);
        check("t3_clamp145", exp_o(1, 5, 0, 1, 0, 0, 1));
        count_value = 8'd150;
        wait_event(12, cyc);
        check_int("t3_done_gap", cyc, 10);
        check("t3_done", exp_o(0, 0, 0, 0, 1, 1, 3));

        // Restart from DONE, then simultaneous start+pause while running.
        step();
        step();
        press(1'b1, 1'b0);
        check("t5_restart", exp_o(0, 0, 1, 1, 0, 0, 1));
        model_en = 1'b1;
        count_value = 8'd0;
        step();
        step();
        press(1'b1, 1'b1);
        check("t5_both", exp_o(0, 0, 0, 0, 0, 0, 2));
        seen = 0;
        repeat (15) begin
            step();
            if (o_inc_pulse || o_clr_pulse) seen++;
        end
        check_int("t5_quiet", seen, 0);
        check("t5_still_paused", exp_o(0, 0, 0, 0, 0, 0, 2));

        // Asynchronous reset in RUN with the divider at 7.
        do_reset("reset_t6");
        step_sel = 1'b0;
        press(1'b1, 1'b0);
        check("t6_start", exp_o(0, 0, 1, 1, 0, 0, 1));
        repeat (7) step();
        rst = 1'b1;
        #1;
        check("t6_async", exp_o(0, 0, 0, 0, 0, 0, 0));
        step();
        step();
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            step();
            if (o_inc_pulse || o_clr_pulse || o_running) seen++;
        end
        check_int("t6_quiet", seen, 0);
        check("t6_idle", exp_o(0, 0, 0, 0, 0, 0, 0));
        press(1'b1, 1'b0);
        check("t6_restart", exp_o(0, 0, 1, 1, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
